// File: rtl/p251_vec_addsub_ctrl_if.sv
// Bus bundle between the p251 vector add/sub sequencer, its operand/result memories and the add/sub unit.
// Defining P251_CTRL_BUSY_ERR_EN adds the sticky o_err flag.
interface p251_vec_addsub_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              i_start;
    logic              i_add_sub;
    logic [ADDR_W:0]   i_len;
    logic              o_busy;
    logic              o_done;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [7:0]        i_a_data;
    logic [7:0]        i_b_data;
    logic [7:0]        o_op1;
    logic [7:0]        o_op2;
    logic              o_add_sub;
    logic              o_op_start;
    logic              i_op_done;
    logic [7:0]        i_op_out;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
`ifdef P251_CTRL_BUSY_ERR_EN
    logic              o_err;
`endif

    modport master (
`ifdef P251_CTRL_BUSY_ERR_EN
        output o_err,
`endif
        input  i_start, i_add_sub, i_len, i_a_data, i_b_data, i_op_done, i_op_out,
        output o_busy, o_done, o_rd_en, o_rd_addr, o_op1, o_op2, o_add_sub, o_op_start,
        output o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
`ifdef P251_CTRL_BUSY_ERR_EN
        input  o_err,
`endif
        output i_start, i_add_sub, i_len, i_a_data, i_b_data, i_op_done, i_op_out,
        input  o_busy, o_done, o_rd_en, o_rd_addr, o_op1, o_op2, o_add_sub, o_op_start,
        input  o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/p251_vec_addsub_ctrl.sv
// Streams r[i] = (a[i] +/- b[i]) mod 251 through one shared p251 add/sub unit, one pair per cycle.
// Optional feature macro: P251_CTRL_BUSY_ERR_EN (sticky o_err, oversize lengths rejected).
module p251_vec_addsub_ctrl #(
    parameter int unsigned N_ELEM = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    p251_vec_addsub_ctrl_if.master bus
);
    localparam int unsigned      LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_ELEM);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] len_in;
    logic             mode_q, mode_d;
    logic             rd_en_q, rd_en_d;
    logic             op_start_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             len_bad, start_ok, wr_fire;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        mode_d   = mode_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_en_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        len_bad  = bus.i_len > LEN_MAX;
        len_in   = len_bad ? LEN_MAX : bus.i_len;
`ifdef P251_CTRL_BUSY_ERR_EN
        start_ok = bus.i_start && !len_bad;
        if (bus.i_start && ((state_q != IDLE) || len_bad)) err_d = 1'b1;
`else
        start_ok = bus.i_start;
`endif
        wr_fire  = bus.i_op_done && ((state_q == ISSUE) || (state_q == DRAIN)) && (wr_cnt_q < len_q);
        if (wr_fire) wr_cnt_d = wr_cnt_q + LEN_W'(1);

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    len_d    = len_in;
                    mode_d   = bus.i_add_sub;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    busy_d   = 1'b1;
                    if (len_in == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rd_cnt_q == len_q - LEN_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                    rd_en_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (wr_cnt_d == len_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // An empty run spends DONE still busy, so its pulse lands one cycle later
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = (len_q == '0);
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            mode_q     <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_en_q    <= 1'b0;
            op_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_en_q    <= rd_en_d;
            op_start_q <= rd_en_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Memory data arrives the cycle after the read, aligned with op_start
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_rd_en    = rd_en_q;
    assign bus.o_rd_addr  = rd_cnt_q[ADDR_W-1:0];
    assign bus.o_op_start = op_start_q;
    assign bus.o_op1      = op_start_q ? bus.i_a_data : 8'd0;
    assign bus.o_op2      = op_start_q ? bus.i_b_data : 8'd0;
    assign bus.o_add_sub  = mode_q;
    assign bus.o_wr_en    = wr_fire;
    assign bus.o_wr_addr  = wr_cnt_q[ADDR_W-1:0];
    assign bus.o_wr_data  = wr_fire ? bus.i_op_out : 8'd0;
`ifdef P251_CTRL_BUSY_ERR_EN
    assign bus.o_err      = err_q;
`else
    logic unused_err;
    assign unused_err = err_q ^ err_d;
`endif
endmodule
